// File: rtl/test_pattern_7segs_pkg.sv
// ---------------------------------------------------------------------------
// test_pattern_pkg
// Shared definitions for the seven-segment test-pattern generator:
//   mode_e        - pattern mode (HEX_UP, HEX_DOWN, BCD_UP, LAMP)
//   RATE_HZ       - step frequency for each of the 16 rate_sel codes
//   period_cycles - clock cycles per step for a given clock and rate_sel
// ---------------------------------------------------------------------------
package test_pattern_pkg;

   typedef enum logic [1:0] {
      HEX_UP   = 2'b00,
      HEX_DOWN = 2'b01,
      BCD_UP   = 2'b10,
      LAMP     = 2'b11
   } mode_e;

   localparam int unsigned RATE_HZ [16] = '{
      1, 2, 5, 10, 20, 50, 100, 200,
      500, 1_000, 2_000, 5_000, 10_000, 20_000, 50_000, 100_000
   };

   // Whole clock cycles per step. Rates faster than the clock collapse to
   // one step per cycle. The clock is a parameter, so this folds into a
   // small constant table.
   function automatic logic [31:0] period_cycles(input int unsigned clkHz,
                                                 input logic [3:0]  rateSel);
      int unsigned p;
      p = clkHz / RATE_HZ[rateSel];
      if (p == 0) begin
         p = 1;
      end
      return p;
   endfunction

endpackage

// File: rtl/test_pattern_7segs_if.sv
// ---------------------------------------------------------------------------
// test_pattern_7segs_if
// Bundles the control and display signals of test_pattern_7segs.
//   count_en, rate_sel, mode, step, load, load_value : controller -> generator
//   disp_value, hex_mode, tick                       : generator -> digit driver
// Modports: master (controller side), slave (generator side).
// ---------------------------------------------------------------------------
interface test_pattern_7segs_if
   import test_pattern_pkg::*;
#(
   parameter int NUM_DIGITS = 6
);
   logic                      count_en;
   logic [3:0]                rate_sel;
   mode_e                     mode;
   logic                      step;
   logic                      load;
   logic [4*NUM_DIGITS-1:0]   load_value;
   logic [4*NUM_DIGITS-1:0]   disp_value;
   logic                      hex_mode;
   logic                      tick;

   modport master (
      output count_en, rate_sel, mode, step, load, load_value,
      input  disp_value, hex_mode, tick
   );

   modport slave (
      input  count_en, rate_sel, mode, step, load, load_value,
      output disp_value, hex_mode, tick
   );
endinterface

// File: rtl/test_pattern_7segs_rate_tick_gen.sv
// ---------------------------------------------------------------------------
// rate_tick_gen
// Prescaler counting 0..period-1 and pulsing step_pulse for one cycle at
// the terminal count.
//   clk, reset  - clock, synchronous active-high reset
//   enable      - counts only while high; holds otherwise
//   restart     - forces the count back to 0 and suppresses the pulse
//   period      - cycles per step (>= 1)
//   step_pulse  - one-cycle step request
// ---------------------------------------------------------------------------
module rate_tick_gen (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        restart,
   input  logic [31:0] period,
   output logic        step_pulse
);
   logic [31:0] count_q;
   logic [31:0] count_d;
   logic        atTerminal;

   // Next count and step pulse. The >= comparison copes with the period
   // shrinking while the count is already beyond the new terminal value.
   always_comb begin
      count_d    = count_q;
      step_pulse = 1'b0;
      atTerminal = (count_q >= (period - 32'd1));
      if (restart) begin
         count_d = '0;
      end else if (enable) begin
         if (atTerminal) begin
            count_d    = '0;
            step_pulse = 1'b1;
         end else begin
            count_d = count_q + 32'd1;
         end
      end
   end

   // Count register, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/test_pattern_7segs.sv
// ---------------------------------------------------------------------------
// test_pattern_7segs
// Generates step-driven test patterns for a multi-digit seven-segment
// display: hex up/down counting, BCD counting, or all-digits lamp test.
//   clk, reset - clock, synchronous active-high reset (highest priority)
//   bus        - test_pattern_7segs_if.slave (controls in, display out)
// Parameters: NUM_DIGITS (1..8), CLK_HZ, INIT_VALUE (reset display value).
// Build option: TEST_PATTERN_STEP_EN enables a synchronised, edge-detected
// manual step input; without it bus.step is ignored.
// ---------------------------------------------------------------------------
module test_pattern_7segs
   import test_pattern_pkg::*;
#(
   parameter int                      NUM_DIGITS = 6,
   parameter int unsigned             CLK_HZ     = 50_000_000,
   parameter logic [4*NUM_DIGITS-1:0] INIT_VALUE = (4*NUM_DIGITS)'(24'hAB_CDEF)
) (
   input logic                  clk,
   input logic                  reset,
   test_pattern_7segs_if.slave  bus
);
   localparam int W = 4 * NUM_DIGITS;

   logic [W-1:0] disp_q;
   logic [W-1:0] disp_d;
   logic [W-1:0] dispNext;
   logic         tick_q;
   logic         tick_d;
   logic [3:0]   rateSel_q;
   logic [31:0]  period;
   logic         restart;
   logic         prescStep;
   logic         manualStep;
   logic         doStep;
   logic         carry;
   logic [3:0]   digit;

   assign period  = period_cycles(CLK_HZ, bus.rate_sel);
   assign restart = bus.load | (bus.rate_sel != rateSel_q);

   rate_tick_gen u_rate_tick_gen (
      .clk        (clk),
      .reset      (reset),
      .enable     (bus.count_en),
      .restart    (restart),
      .period     (period),
      .step_pulse (prescStep)
   );

`ifdef TEST_PATTERN_STEP_EN
   logic stepSync1_q;
   logic stepSync2_q;
   logic stepPrev_q;

   // Two-flop synchroniser for the asynchronous step level, plus a delayed
   // copy so only the rising edge produces a step.
   always_ff @(posedge clk) begin
      if (reset) begin
         stepSync1_q <= 1'b0;
         stepSync2_q <= 1'b0;
         stepPrev_q  <= 1'b0;
      end else begin
         stepSync1_q <= bus.step;
         stepSync2_q <= stepSync1_q;
         stepPrev_q  <= stepSync2_q;
      end
   end

   assign manualStep = stepSync2_q & ~stepPrev_q;
`else
   logic unusedStep;
   assign unusedStep = bus.step;
   assign manualStep = 1'b0;
`endif

   // A manual step coinciding with a prescaler step still counts once.
   assign doStep = prescStep | manualStep;

   // Value the display takes on a step, chosen by the current mode. BCD
   // ripples a carry from digit 0 upward; any non-decimal digit reached by
   // the carry is treated like 9 and rolls to 0.
   always_comb begin
      dispNext = disp_q;
      carry    = 1'b1;
      digit    = '0;
      case (bus.mode)
         HEX_UP:   dispNext = disp_q + W'(1);
         HEX_DOWN: dispNext = disp_q - W'(1);
         BCD_UP: begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               digit = disp_q[4*i +: 4];
               if (carry) begin
                  if (digit >= 4'd9) begin
                     dispNext[4*i +: 4] = 4'd0;
                  end else begin
                     dispNext[4*i +: 4] = digit + 4'd1;
                     carry              = 1'b0;
                  end
               end
            end
         end
         LAMP: begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               dispNext[4*i +: 4] = disp_q[3:0] + 4'd1;
            end
         end
         default: dispNext = disp_q;
      endcase
   end

   // Display update: a load wins over a step in the same cycle and never
   // raises tick.
   always_comb begin
      disp_d = disp_q;
      tick_d = 1'b0;
      if (bus.load) begin
         disp_d = bus.load_value;
      end else if (doStep) begin
         disp_d = dispNext;
         tick_d = 1'b1;
      end
   end

   // State registers. rateSel_q takes the live rate during reset so that
   // coming out of reset is not mistaken for a rate change.
   always_ff @(posedge clk) begin
      if (reset) begin
         disp_q    <= INIT_VALUE;
         tick_q    <= 1'b0;
         rateSel_q <= bus.rate_sel;
      end else begin
         disp_q    <= disp_d;
         tick_q    <= tick_d;
         rateSel_q <= bus.rate_sel;
      end
   end

   assign bus.disp_value = disp_q;
   assign bus.tick       = tick_q;
   assign bus.hex_mode   = (bus.mode != BCD_UP);
endmodule
